// File: rtl/calc_operand_sequencer.sv
// calc_operand_sequencer
//   Sequential front end of the 8-bit add/subtract calculator. It debounces
//   the enter button, captures operand A, then operand B together with the
//   operation select, and holds the two's-complement result and its signed
//   overflow flag for the signed-magnitude display stage.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   data_in[7:0] switch value (two's-complement operand)
//   op           0 = A+B, 1 = A-B
//   enter        raw push button (asynchronous, bouncy)
//   disp_value   registered value for the display stage
//   state[1:0]   00 LOAD_A, 01 LOAD_B, 10 SHOW_RESULT
//   overflow     signed overflow of the last computed result
//   result_valid high while in SHOW_RESULT
module calc_operand_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       op,
  input  logic       enter,
  output logic [7:0] disp_value,
  output logic [1:0] state,
  output logic       overflow,
  output logic       result_valid
);

  typedef enum logic [1:0] {
    LOAD_A      = 2'b00,
    LOAD_B      = 2'b01,
    SHOW_RESULT = 2'b10
  } state_t;

  // The counter reaching DEBOUNCE_CYCLES is the edge on which it would have
  // been incremented from DEBOUNCE_CYCLES-1.
  localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

  state_t      state_q, state_d;
  logic        sync1, sync2;
  logic        stable, stable_d;
  logic [19:0] cnt;
  logic        press;

  logic [7:0]  a_q;
  logic [7:0]  result_q;
  logic        overflow_q;

  logic [7:0]  alu_res;
  logic        alu_ovf;

  // ---------------- synchroniser + debouncer ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= enter;
      sync2    <= sync1;
      stable_d <= stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

  // One-cycle event on the accepted 0->1 transition only.
  assign press = stable & ~stable_d;

  // ---------------- ALU (operand B is data_in at the capture edge) -------
  always_comb begin
    alu_res = op ? (a_q - data_in) : (a_q + data_in);
    if (op)
      alu_ovf = (a_q[7] != data_in[7]) && (alu_res[7] != a_q[7]);
    else
      alu_ovf = (a_q[7] == data_in[7]) && (alu_res[7] != a_q[7]);
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= LOAD_A;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_A:      if (press) state_d = LOAD_B;
      LOAD_B:      if (press) state_d = SHOW_RESULT;
      SHOW_RESULT: if (press) state_d = LOAD_A;
      default:     state_d = LOAD_A;
    endcase
  end

  // ---------------- datapath / registered outputs ----------------
  // B and op are only consumed on the LOAD_B capture edge; result and
  // overflow hold everything needed afterwards, so they are not kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q          <= '0;
      result_q     <= '0;
      overflow_q   <= 1'b0;
      disp_value   <= '0;
      result_valid <= 1'b0;
    end else begin
      if (state_q == LOAD_A && press)
        a_q <= data_in;
      if (state_q == LOAD_B && press) begin
        result_q   <= alu_res;
        overflow_q <= alu_ovf;
      end
      if (state_q == SHOW_RESULT && press)
        overflow_q <= 1'b0;

      result_valid <= (state_d == SHOW_RESULT);

      // Look at the next state so the display switches on the same edge
      // as the state register.
      if (state_d == SHOW_RESULT)
        disp_value <= (state_q == LOAD_B) ? alu_res : result_q;
      else
        disp_value <= data_in;
    end
  end

  assign state    = state_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Directed testbench for calc_operand_sequencer (DEBOUNCE_CYCLES = 4).
module tb_calc_operand_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       op;
  logic       enter;
  logic [7:0] disp_value;
  logic [1:0] state;
  logic       overflow;
  logic       result_valid;

  int n_chk  = 0;
  int n_fail = 0;

  calc_operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .op           (op),
    .enter        (enter),
    .disp_value   (disp_value),
    .state        (state),
    .overflow     (overflow),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press: held long enough to debounce, then released and settled.
  task automatic press();
    enter = 1'b1;
    cycles(12);
    enter = 1'b0;
    cycles(12);
  endtask

  task automatic compute(input logic [7:0] a, input logic [7:0] b, input logic o);
    data_in = a;
    press();
    data_in = b;
    op      = o;
    press();
  endtask

  initial begin
    reset   = 1'b1;
    data_in = 8'h00;
    op      = 1'b0;
    enter   = 1'b0;
    cycles(2);
    reset = 1'b0;
    cycles(3);
    chk("rst_state", {6'd0, state}, 8'h00);
    chk("rst_disp", disp_value, 8'h00);
    chk("rst_ovf", {7'd0, overflow}, 8'h00);
    chk("rst_valid", {7'd0, result_valid}, 8'h00);

    // Glitch shorter than the debounce window
    enter = 1'b1;
    cycles(3);
    enter = 1'b0;
    cycles(10);
    chk("short_press_state", {6'd0, state}, 8'h00);

    // 25 + 17 = 42
    compute(8'd25, 8'd17, 1'b0);
    chk("add_state", {6'd0, state}, 8'h02);
    chk("add_disp", disp_value, 8'h2A);
    chk("add_ovf", {7'd0, overflow}, 8'h00);
    chk("add_valid", {7'd0, result_valid}, 8'h01);
    press();
    chk("back_state", {6'd0, state}, 8'h00);
    chk("back_echo", disp_value, 8'h11);
    chk("back_valid", {7'd0, result_valid}, 8'h00);
    data_in = 8'h3C;
    cycles(2);
    chk("live_echo", disp_value, 8'h3C);

    // 10 - 30 = -20, then inputs change while showing
    compute(8'h0A, 8'h1E, 1'b1);
    chk("sub_disp", disp_value, 8'hEC);
    chk("sub_ovf", {7'd0, overflow}, 8'h00);
    data_in = 8'h55;
    op      = 1'b0;
    cycles(3);
    chk("hold_disp", disp_value, 8'hEC);
    chk("hold_state", {6'd0, state}, 8'h02);
    press();

    // 127 + 1 -> 0x80 overflow
    compute(8'h7F, 8'h01, 1'b0);
    chk("add_wrap_disp", disp_value, 8'h80);
    chk("add_wrap_ovf", {7'd0, overflow}, 8'h01);
    press();
    chk("ovf_clear", {7'd0, overflow}, 8'h00);

    // -128 - 1 -> 127 overflow
    compute(8'h80, 8'h01, 1'b1);
    chk("sub_wrap_disp", disp_value, 8'h7F);
    chk("sub_wrap_ovf", {7'd0, overflow}, 8'h01);
    press();

    // -128 + -128 -> 0 overflow
    compute(8'h80, 8'h80, 1'b0);
    chk("neg_add_disp", disp_value, 8'h00);
    chk("neg_add_ovf", {7'd0, overflow}, 8'h01);
    press();

    // 0 - (-128) -> 0x80 overflow
    compute(8'h00, 8'h80, 1'b1);
    chk("neg_sub_disp", disp_value, 8'h80);
    chk("neg_sub_ovf", {7'd0, overflow}, 8'h01);
    press();
    chk("pre_bounce_state", {6'd0, state}, 8'h00);

    // Bouncing then stable press -> one advance
    data_in = 8'h05;
    for (int i = 0; i < 10; i++) begin
      enter = ~enter;
      cycles(1);
    end
    enter = 1'b1;
    cycles(20);
    enter = 1'b0;
    cycles(20);
    chk("bounce_state", {6'd0, state}, 8'h01);

    // Long hold -> one advance
    data_in = 8'h03;
    op      = 1'b0;
    enter   = 1'b1;
    cycles(100);
    enter = 1'b0;
    cycles(20);
    chk("hold_press_state", {6'd0, state}, 8'h02);
    chk("hold_press_disp", disp_value, 8'h08);
    press();

    // Reset in LOAD_B with the debouncer mid-count
    data_in = 8'h05;
    press();
    chk("pre_reset_state", {6'd0, state}, 8'h01);
    enter = 1'b1;
    cycles(4);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    enter = 1'b0;
    chk("mid_reset_state", {6'd0, state}, 8'h00);
    chk("mid_reset_disp", disp_value, 8'h00);
    chk("mid_reset_ovf", {7'd0, overflow}, 8'h00);
    cycles(10);
    chk("mid_reset_no_adv", {6'd0, state}, 8'h00);

    // First press after reset lands in A: 9 + 1 = 10
    compute(8'h09, 8'h01, 1'b0);
    chk("post_reset_disp", disp_value, 8'h0A);
    chk("post_reset_state", {6'd0, state}, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
